// File: rtl/alu_issue.sv
//------------------------------------------------------------------------------
// alu_issue : RV32I issue stage; decodes ALU op/operands into a 2-entry skid buffer.
// Optional macro ALU_ISSUE_PERF_EN adds perf_issued / perf_stall counters.
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_issue #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  out_op,
  output logic [XLEN-1:0] out_alu_a,
  output logic [XLEN-1:0] out_alu_b,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_stall
`endif
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  localparam logic [OPW-1:0] ALU_ADD   = OPW'(4'h0);
  localparam logic [OPW-1:0] ALU_SUB   = OPW'(4'h1);
  localparam logic [OPW-1:0] ALU_AND   = OPW'(4'h2);
  localparam logic [OPW-1:0] ALU_OR    = OPW'(4'h3);
  localparam logic [OPW-1:0] ALU_XOR   = OPW'(4'h4);
  localparam logic [OPW-1:0] ALU_LINK  = OPW'(4'h6);
  localparam logic [OPW-1:0] ALU_SLTU  = OPW'(4'h7);
  localparam logic [OPW-1:0] ALU_SLT   = OPW'(4'h8);
  localparam logic [OPW-1:0] ALU_SLL   = OPW'(4'h9);
  localparam logic [OPW-1:0] ALU_SRL   = OPW'(4'hA);
  localparam logic [OPW-1:0] ALU_SRA   = OPW'(4'hB);
  localparam logic [OPW-1:0] ALU_PASSB = OPW'(4'hC);

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd;
    logic            we;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state;
  entry_t head;
  entry_t tail;
  entry_t dec;
  logic   legal;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;

  assign opc   = in_instr[6:0];
  assign rd    = in_instr[11:7];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign shamt = XLEN'(in_instr[24:20]);

  function automatic logic [OPW-1:0] base_op(input logic [2:0] fn3, input logic alt);
    case (fn3)
      3'b000:  base_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec    = '0;
    legal  = 1'b1;
    dec.rd = rd;
    case (opc)
      OPC_OP: begin
        dec.a  = in_rs1_data;
        dec.b  = in_rs2_data;
        dec.op = base_op(f3, f7[5]);
        legal  = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_IMM: begin
        // OP-IMM never encodes sub; only the right shift uses funct7 as a selector
        dec.a  = in_rs1_data;
        dec.b  = imm_i;
        dec.op = base_op(f3, 1'b0);
        if (f3 == 3'b001) begin
          dec.b = shamt;
          legal = (f7 == 7'h00);
        end else if (f3 == 3'b101) begin
          dec.b  = shamt;
          dec.op = base_op(f3, f7[5]);
          legal  = (f7 == 7'h00) || (f7 == 7'h20);
        end
      end
      OPC_LUI: begin
        dec.op = ALU_PASSB;
        dec.b  = imm_u;
      end
      OPC_AUIPC: begin
        dec.op = ALU_ADD;
        dec.a  = in_pc;
        dec.b  = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        dec.op = ALU_LINK;
        dec.a  = in_pc;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.op = ALU_ADD;
      dec.a  = '0;
      dec.b  = '0;
    end
    dec.illegal = !legal;
    dec.we      = legal && (rd != 5'd0);
  end

  // head drives out_* directly; tail only holds the second entry while FULL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      state <= S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (in_valid) begin
            head  <= dec;
            state <= S_ONE;
          end
        end
        S_ONE: begin
          case ({in_valid, out_ready})
            2'b10: begin
              tail  <= dec;
              state <= S_FULL;
            end
            2'b01: state <= S_EMPTY;
            2'b11: head  <= dec;
            default: ;
          endcase
        end
        S_FULL: begin
          if (out_ready) begin
            head  <= tail;
            state <= S_ONE;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  assign in_ready    = (state != S_FULL);
  assign out_valid   = (state != S_EMPTY);
  assign out_op      = head.op;
  assign out_alu_a   = head.a;
  assign out_alu_b   = head.b;
  assign out_rd      = head.rd;
  assign out_we      = head.we;
  assign out_illegal = head.illegal;

`ifdef ALU_ISSUE_PERF_EN
  // counters survive flush; only rst clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (out_valid && out_ready) perf_issued <= perf_issued + 32'd1;
      if (in_valid && !in_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  // no performance counters in this build
`endif

endmodule

`default_nettype wire

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue stage between the register-read stage and the 4-bit-op ALU of the RV32I core.
- Decodes each instruction into the ALU op code, selects operand A and operand B, and determines rd and the write-enable.
- Buffers results in a 2-entry skid buffer with valid/ready handshakes on both sides, so a stalled execute stage does not drop issue throughput.

Parameters:
- XLEN, 32, datapath width of operands and PC
- OPW, 4, width of the ALU op code

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous kill of all buffered entries (branch/trap redirect)
- in_valid  input  1  upstream holds a valid instruction
- in_ready  output  1  stage can accept an instruction this cycle
- in_instr  input  32  raw instruction word
- in_pc  input  XLEN  instruction PC
- in_rs1_data  input  XLEN  rs1 register value
- in_rs2_data  input  XLEN  rs2 register value
- out_valid  output  1  head entry valid
- out_ready  input  1  execute stage consumes the head entry
- out_op  output  OPW  ALU op code
- out_alu_a  output  XLEN  operand A
- out_alu_b  output  XLEN  operand B
- out_rd  output  5  destination register
- out_we  output  1  register writeback enable
- out_illegal  output  1  instruction not decodable by this stage

Behaviour:
- Op map: 0 add, 1 sub, 2 and, 3 or, 4 xor, 6 a+4, 7 sltu, 8 slt, 9 sll, A srl, B sra, C pass-b. No other codes are emitted.
- OP 0110011: funct3 selects 000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and. funct7=0x20 selects sub/sra. funct7 legal values: 0x00 always; 0x20 only with funct3 000/101. Operands a=rs1_data, b=rs2_data.
- OP-IMM 0010011: same funct3 map, but 000 is always add.
  - b = sign-extended I-immediate; for shifts b = zero-extended shamt [24:20].
  - slli requires funct7=0x00.
  - srli/srai require funct7 0x00 or 0x20; 0x20 selects srai.
- LUI 0110111: op C, b = {instr[31:12], 12'b0}, a = 0.
- AUIPC 0010111: op 0, a = pc, b = U-immediate.
- JAL 1101111 and JALR 1100111: op 6, a = pc, b = 0. This produces the link value.
- Any other opcode or illegal funct7: op 0, a = b = 0, we = 0, illegal = 1.
- we = 1 iff the instruction is legal and rd != 0.
- Handshake: a transfer occurs on an edge where valid && ready.
  - Decode is combinational from the in_* ports; the decoded entry is registered on acceptance.
  - Latency is 1 cycle: an instruction accepted at edge N is visible on out_* after edge N.
- in_ready = !FULL. It is derived from the registered state only, never from out_ready.
- Buffer states and transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept without pop -> FULL; pop without accept -> EMPTY; accept and pop together -> ONE (new entry becomes head).
  - FULL: pop -> ONE; no accept is possible.
- Strict FIFO order. out_* reflect the head entry and are stable while out_valid && !out_ready.
- flush: at the next edge the state goes to EMPTY and out_valid=0. An input presented in the same cycle is discarded, even if in_valid && in_ready. A pop in the same cycle has no further effect.
- Reset (async assert, any state, mid-transfer included): state EMPTY. out_valid=0, in_ready=1 after reset. out_op, out_alu_a, out_alu_b, out_rd, out_we and out_illegal are all 0.
- out_* are don't-care-free: they hold the last head contents, or 0 after reset, when out_valid=0.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN.
- When defined, adds two output ports, each 32 bits, reset to 0, and cleared by rst only (not by flush):
  - perf_issued: increments on every output transfer.
  - perf_stall: increments on every cycle with in_valid && !in_ready.
  - Both counters wrap from 0xFFFFFFFF to 0.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
- ADDI x5,x1,-1 (0xFFF08293), rs1_data=0x10, out_ready=1 -> next cycle op=0, a=0x10, b=0xFFFFFFFF, rd=5, we=1, illegal=0.
- SUB x3,x1,x2 (0x402081B3) then SRAI x4,x1,3 (0x4030D213) back-to-back -> op=1, then op=B with b=3; one result per cycle.
- LUI x7,0x12345 (0x123453B7) -> op=C, b=0x12345000. JAL x1 (0x008000EF) with pc=0x100 -> op=6, a=0x100, b=0, rd=1, we=1.
- out_ready=0 while three instructions are offered:
  - First two are accepted, then in_ready=0 (stall counter increments if PERF_EN).
  - Raise out_ready -> outputs drain in order with no loss or duplication.
- FULL state with flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, offered instruction dropped. ADD x0,x1,x2 (0x00208033) -> we=0. Opcode 0x7F -> illegal=1, we=0.
- Assert rst asynchronously mid-cycle while FULL -> outputs 0 immediately, out_valid=0; after release the first accepted instruction issues normally.
